// File: rtl/display_scheduler.sv
// Time-multiplexed 4-digit display scan sharing one BCD converter among three plant counters.
// Optional leading-zero blanking of the tens digit: define DISPLAY_BLANK_EN.
module display_scheduler #(
  parameter int SCAN_DIV      = 50000,
  parameter int ROTATE_FRAMES = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] cnt_bottles,
  input  logic [4:0] cnt_corks,
  input  logic [4:0] cnt_boxes,
  input  logic [1:0] sel_mode,
  input  logic [3:0] bcd_dezena,
  input  logic [3:0] bcd_unidade,
  output logic [4:0] conv_bin,
  output logic [3:0] seg_digit,
  output logic [3:0] digit_en,
  output logic [1:0] src_id,
  output logic       frame_tick
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int RW = $clog2(ROTATE_FRAMES + 1);

  typedef enum logic [1:0] {S0, S1, S2, S3} slot_t;

  logic [PW-1:0] prescaler;
  logic          tick;
  slot_t         slot, slot_nxt;
  logic [RW-1:0] rot, rot_nxt;
  logic [1:0]    src_nxt;
  logic [4:0]    snap_nxt;
  logic [3:0]    de_nxt, seg_nxt, tens_shown;
  logic          ft_nxt;

  assign tick = (prescaler == PW'(SCAN_DIV - 1));

`ifdef DISPLAY_BLANK_EN
  assign tens_shown = (bcd_dezena == 4'd0) ? 4'hF : bcd_dezena;
`else
  assign tens_shown = bcd_dezena;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler  <= '0;
      slot       <= S3;
      rot        <= '0;
      src_id     <= 2'd0;
      conv_bin   <= '0;
      digit_en   <= '1;
      seg_digit  <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      prescaler  <= tick ? '0 : prescaler + 1'b1;
      slot       <= slot_nxt;
      rot        <= rot_nxt;
      src_id     <= src_nxt;
      conv_bin   <= snap_nxt;
      digit_en   <= de_nxt;
      seg_digit  <= seg_nxt;
      frame_tick <= ft_nxt;
    end
  end

  always_comb begin
    slot_nxt = slot;
    rot_nxt  = rot;
    src_nxt  = src_id;
    snap_nxt = conv_bin;
    de_nxt   = digit_en;
    seg_nxt  = seg_digit;
    ft_nxt   = 1'b0;
    if (tick) begin
      case (slot)
        S3: begin
          // Frame boundary: choose the source, then freeze its counter for the whole frame.
          slot_nxt = S0;
          ft_nxt   = 1'b1;
          de_nxt   = 4'b0111;
          if (sel_mode != 2'b00) begin
            src_nxt = sel_mode - 2'd1;
            rot_nxt = '0;
          end else if (rot == RW'(ROTATE_FRAMES - 1)) begin
            rot_nxt = '0;
            src_nxt = (src_id == 2'd2) ? 2'd0 : src_id + 2'd1;
          end else begin
            rot_nxt = rot + 1'b1;
          end
          case (src_nxt)
            2'd0:    snap_nxt = cnt_bottles;
            2'd1:    snap_nxt = cnt_corks;
            default: snap_nxt = cnt_boxes;
          endcase
          seg_nxt = {2'b00, src_nxt} + 4'd1;
        end
        S0: begin
          slot_nxt = S1;
          de_nxt   = 4'b1011;
          seg_nxt  = 4'hF;
        end
        S1: begin
          slot_nxt = S2;
          de_nxt   = 4'b1101;
          seg_nxt  = tens_shown;
        end
        default: begin
          slot_nxt = S3;
          de_nxt   = 4'b1110;
          seg_nxt  = bcd_unidade;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler against a cycle-count based reference model.
module tb_display_scheduler;
  localparam int SD = 4;
  localparam int RF = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] cnt_bottles = '0, cnt_corks = '0, cnt_boxes = '0;
  logic [1:0] sel_mode = 2'b01;
  logic [3:0] bcd_dezena, bcd_unidade;
  logic [4:0] conv_bin;
  logic [3:0] seg_digit, digit_en;
  logic [1:0] src_id;
  logic       frame_tick;

  display_scheduler #(.SCAN_DIV(SD), .ROTATE_FRAMES(RF)) dut (
    .clk(clk), .reset(reset), .cnt_bottles(cnt_bottles), .cnt_corks(cnt_corks),
    .cnt_boxes(cnt_boxes), .sel_mode(sel_mode), .bcd_dezena(bcd_dezena),
    .bcd_unidade(bcd_unidade), .conv_bin(conv_bin), .seg_digit(seg_digit),
    .digit_en(digit_en), .src_id(src_id), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // External combinational binary-to-BCD converter.
  always_comb begin
    bcd_dezena  = 4'(conv_bin / 5'd10);
    bcd_unidade = 4'(conv_bin % 5'd10);
  end

  int errors = 0;
  int checks = 0;

  // Reference model: position in the scan derived from the number of edges since reset.
  int       n = 0;
  int       m_rot = 0;
  bit [1:0] m_src = 0;
  bit [4:0] m_conv = 0;
  bit [3:0] m_de = 4'b1111, m_seg = 4'hF;
  bit       m_ft = 0;

`ifdef DISPLAY_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  task automatic step();
    bit       r = reset;
    bit [1:0] s = sel_mode;
    bit [4:0] c[3];
    int       slot_idx;
    c[0] = cnt_bottles; c[1] = cnt_corks; c[2] = cnt_boxes;
    @(posedge clk);
    if (r) begin
      n = 0; m_rot = 0; m_src = 0; m_conv = 0;
      m_de = 4'b1111; m_seg = 4'hF; m_ft = 0;
    end else begin
      n++;
      m_ft = 0;
      if (n >= SD && (n - SD) % SD == 0) begin
        slot_idx = ((n - SD) / SD) % 4;
        case (slot_idx)
          0: begin
            if (s != 0) begin
              m_src = s - 1; m_rot = 0;
            end else begin
              m_rot++;
              if (m_rot == RF) begin m_rot = 0; m_src = (m_src + 1) % 3; end
            end
            m_conv = c[m_src];
            m_de = 4'b0111; m_seg = 4'(m_src + 1); m_ft = 1;
          end
          1: begin m_de = 4'b1011; m_seg = 4'hF; end
          2: begin
            m_de = 4'b1101;
            m_seg = (BLANK && m_conv < 10) ? 4'hF : 4'(m_conv / 10);
          end
          default: begin m_de = 4'b1110; m_seg = 4'(m_conv % 10); end
        endcase
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({digit_en, seg_digit, frame_tick, src_id, conv_bin} !== {4'b1111, 4'hF, 1'b0, 2'd0, 5'd0}) begin
      errors++; $display("FAIL reset_values got=%h exp=%h", {digit_en, seg_digit, frame_tick, src_id, conv_bin}, {4'b1111, 4'hF, 1'b0, 2'd0, 5'd0});
    end
    reset = 1'b0; sel_mode = 2'b01; cnt_bottles = 5'd23;
    for (int i = 0; i < SD - 1; i++) begin
      step();
      checks++;
      if (digit_en !== 4'b1111) begin
        errors++; $display("FAIL dark_after_reset i=%0d got=%b exp=1111", i, digit_en);
      end
    end
    step();
    checks++;
    if ({digit_en, seg_digit, frame_tick, conv_bin} !== {4'b0111, 4'd1, 1'b1, 5'd23}) begin
      errors++; $display("FAIL first_s0 got=%h exp=%h", {digit_en, seg_digit, frame_tick, conv_bin}, {4'b0111, 4'd1, 1'b1, 5'd23});
    end
    for (int k = 2; k <= 4 * SD; k++) begin
      step();
      checks++;
      if ({digit_en, seg_digit, frame_tick, src_id, conv_bin} !== {m_de, m_seg, m_ft, m_src, m_conv}) begin
        errors++; $display("FAIL first_frame k=%0d got=%h exp=%h", k, {digit_en, seg_digit, frame_tick, src_id, conv_bin}, {m_de, m_seg, m_ft, m_src, m_conv});
      end
      if (k == SD + 1 || k == 2 * SD + 1 || k == 3 * SD + 1) begin
        checks++;
        if (seg_digit !== ((k == SD + 1) ? 4'hF : (k == 2 * SD + 1) ? 4'd2 : 4'd3)) begin
          errors++; $display("FAIL frame_23_digit k=%0d got=%h", k, seg_digit);
        end
      end
    end
  endtask

  task automatic test_blank();
    cnt_bottles = 5'd7;
    for (int k = 1; k <= 4 * SD; k++) begin
      step();
      checks++;
      if ({digit_en, seg_digit, frame_tick, src_id, conv_bin} !== {m_de, m_seg, m_ft, m_src, m_conv}) begin
        errors++; $display("FAIL blank k=%0d got=%h exp=%h", k, {digit_en, seg_digit, frame_tick, src_id, conv_bin}, {m_de, m_seg, m_ft, m_src, m_conv});
      end
      if (k == 2 * SD + 1) begin
        checks++;
        if (seg_digit !== (BLANK ? 4'hF : 4'd0)) begin
          errors++; $display("FAIL blank_tens got=%h exp=%h", seg_digit, BLANK ? 4'hF : 4'd0);
        end
      end
      if (k == 3 * SD + 1) begin
        checks++;
        if (seg_digit !== 4'd7) begin
          errors++; $display("FAIL units_7 got=%h exp=7", seg_digit);
        end
      end
    end
  endtask

  task automatic test_midframe_change();
    cnt_bottles = 5'd23;
    for (int k = 1; k <= 8 * SD; k++) begin
      step();
      if (k == SD + 2) cnt_bottles = 5'd9;
      checks++;
      if ({digit_en, seg_digit, frame_tick, src_id, conv_bin} !== {m_de, m_seg, m_ft, m_src, m_conv}) begin
        errors++; $display("FAIL midframe k=%0d got=%h exp=%h", k, {digit_en, seg_digit, frame_tick, src_id, conv_bin}, {m_de, m_seg, m_ft, m_src, m_conv});
      end
      if (k == 2 * SD + 1 || k == 3 * SD + 1) begin
        checks++;
        if (seg_digit !== ((k == 2 * SD + 1) ? 4'd2 : 4'd3)) begin
          errors++; $display("FAIL frozen_snapshot k=%0d got=%h", k, seg_digit);
        end
      end
      if (k == 7 * SD + 1) begin
        checks++;
        if (seg_digit !== 4'd9) begin
          errors++; $display("FAIL new_snapshot got=%h exp=9", seg_digit);
        end
      end
    end
  endtask

  task automatic test_auto_rotate();
    sel_mode = 2'b00;
    for (int k = 1; k <= 7 * 4 * SD; k++) begin
      step();
      checks++;
      if ({digit_en, seg_digit, frame_tick, src_id, conv_bin} !== {m_de, m_seg, m_ft, m_src, m_conv}) begin
        errors++; $display("FAIL auto_rotate k=%0d got=%h exp=%h", k, {digit_en, seg_digit, frame_tick, src_id, conv_bin}, {m_de, m_seg, m_ft, m_src, m_conv});
      end
    end
    for (int k = 1; k <= 4 * SD; k++) begin
      step();
      if (k == SD + 2) sel_mode = 2'b11;
      checks++;
      if ({digit_en, seg_digit, frame_tick, src_id, conv_bin} !== {m_de, m_seg, m_ft, m_src, m_conv}) begin
        errors++; $display("FAIL auto_switch k=%0d got=%h exp=%h", k, {digit_en, seg_digit, frame_tick, src_id, conv_bin}, {m_de, m_seg, m_ft, m_src, m_conv});
      end
    end
    step();
    checks++;
    if ({src_id, seg_digit, digit_en} !== {2'd2, 4'd3, 4'b0111}) begin
      errors++; $display("FAIL switch_to_boxes got=%h exp=%h", {src_id, seg_digit, digit_en}, {2'd2, 4'd3, 4'b0111});
    end
    for (int k = 2; k <= 4 * SD; k++) step();
  endtask

  task automatic test_corks();
    cnt_corks = 5'd31; sel_mode = 2'b10;
    for (int k = 1; k <= 4 * SD; k++) begin
      step();
      checks++;
      if ({digit_en, seg_digit, frame_tick, src_id, conv_bin} !== {m_de, m_seg, m_ft, m_src, m_conv}) begin
        errors++; $display("FAIL corks k=%0d got=%h exp=%h", k, {digit_en, seg_digit, frame_tick, src_id, conv_bin}, {m_de, m_seg, m_ft, m_src, m_conv});
      end
      if (k == 1) begin
        checks++;
        if ({conv_bin, seg_digit} !== {5'd31, 4'd2}) begin
          errors++; $display("FAIL corks_s0 got=%h exp=%h", {conv_bin, seg_digit}, {5'd31, 4'd2});
        end
      end
      if (k == 2 * SD + 1 || k == 3 * SD + 1) begin
        checks++;
        if (seg_digit !== ((k == 2 * SD + 1) ? 4'd3 : 4'd1)) begin
          errors++; $display("FAIL corks_digit k=%0d got=%h", k, seg_digit);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    for (int k = 1; k <= 2 * SD + 2; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({digit_en, seg_digit, conv_bin, frame_tick} !== {4'b1111, 4'hF, 5'd0, 1'b0}) begin
      errors++; $display("FAIL reset_midframe got=%h exp=%h", {digit_en, seg_digit, conv_bin, frame_tick}, {4'b1111, 4'hF, 5'd0, 1'b0});
    end
    for (int i = 0; i < SD - 1; i++) begin
      step();
      checks++;
      if (digit_en !== 4'b1111) begin
        errors++; $display("FAIL dark_after_midreset i=%0d got=%b", i, digit_en);
      end
    end
    step();
    checks++;
    if ({digit_en, frame_tick} !== {4'b0111, 1'b1}) begin
      errors++; $display("FAIL s0_after_midreset got=%h exp=%h", {digit_en, frame_tick}, {4'b0111, 1'b1});
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(0, 5) == 0) sel_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) cnt_bottles = 5'($urandom);
      if ($urandom_range(0, 3) == 0) cnt_corks = 5'($urandom);
      if ($urandom_range(0, 3) == 0) cnt_boxes = 5'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      step();
      checks++;
      if ({digit_en, seg_digit, frame_tick, src_id, conv_bin} !== {m_de, m_seg, m_ft, m_src, m_conv}) begin
        errors++; $display("FAIL random k=%0d got=%h exp=%h", k, {digit_en, seg_digit, frame_tick, src_id, conv_bin}, {m_de, m_seg, m_ft, m_src, m_conv});
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_blank();
    test_midframe_change();
    test_auto_rotate();
    test_corks();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
